id_branch_hazard_ctrl: RTL and testbench

Decode-stage control block for the SPARC pipeline. It sits directly downstream of the IF/ID register and consumes its instruction and PC. It resolves Bicc/CALL/JMPL control transfers, generates the IF-stage PC mux select, target address, load enables and IF/ID clear, and stalls on load-use and condition-code hazards. It tracks SPARC delay-slot annulment across cycles and keeps saturating performance counters.

---
 rtl/sparc_pkg.sv | 34 +++
 rtl/id_cond_eval.sv | 30 +++
 rtl/id_branch_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_id_branch_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_pkg.sv
// Shared SPARC decode constants, branch condition codes, IF mux selects and
// the decode-stage FSM state encoding.
package sparc_pkg;

    localparam logic [1:0] OP_FMT2 = 2'b00;
    localparam logic [1:0] OP_CALL = 2'b01;
    localparam logic [1:0] OP_ARITH = 2'b10;
    localparam logic [1:0] OP_MEM = 2'b11;

    localparam logic [2:0] OP2_BICC = 3'b010;
    localparam logic [5:0] OP3_JMPL = 6'b111000;
    // op3[5:2] shared by all integer store opcodes
    localparam logic [3:0] OP3_STORE_HI = 4'b0001;

    localparam logic [3:0] COND_BN = 4'b0000;
    localparam logic [3:0] COND_BE = 4'b0001;
    localparam logic [3:0] COND_BLE = 4'b0010;
    localparam logic [3:0] COND_BL = 4'b0011;
    localparam logic [3:0] COND_BLEU = 4'b0100;
    localparam logic [3:0] COND_BCS = 4'b0101;
    localparam logic [3:0] COND_BNEG = 4'b0110;
    localparam logic [3:0] COND_BVS = 4'b0111;
    localparam logic [3:0] COND_BA = 4'b1000;
    localparam logic [3:0] COND_BNE = 4'b1001;

    localparam logic [1:0] SEL_NPC = 2'b00;
    localparam logic [1:0] SEL_TA = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;

    typedef logic [0:0] state_t;
    localparam state_t ST_RUN = 1'b0;
    localparam state_t ST_SQUASH = 1'b1;

endpackage

// File: rtl/id_cond_eval.sv
// Bicc condition evaluation against {N,Z,V,C}; cond[3] inverts the base test.
module id_cond_eval (
    input  logic [3:0] cond,
    input  logic [3:0] icc,
    output logic       taken
);

    logic n, z, v, c;
    logic base;

    assign {n, z, v, c} = icc;

    always_comb begin
        base = 1'b0;
        case (cond[2:0])
            3'd0: base = 1'b0;
            3'd1: base = z;
            3'd2: base = z | (n ^ v);
            3'd3: base = n ^ v;
            3'd4: base = c | z;
            3'd5: base = c;
            3'd6: base = n;
            3'd7: base = v;
            default: base = 1'b0;
        endcase
    end

    assign taken = cond[3] ? ~base : base;

endmodule

// File: rtl/id_branch_hazard_ctrl.sv
// Decode-stage control: resolves Bicc/CALL/JMPL, drives the IF PC mux and load
// enables, stalls on load-use / icc hazards and annuls delay slots.
module id_branch_hazard_ctrl
    import sparc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             R_n,
    input  logic [31:0]      instruction_in,
    input  logic [31:0]      pc_in,
    input  logic [3:0]       icc,
    input  logic             ex_sets_cc,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             cnt_clr,
    output logic [1:0]       pc_sel,
    output logic [31:0]      ta,
    output logic             pc_le,
    output logic             npc_le,
    output logic             ifid_le,
    output logic             ifid_clear,
    output logic             idex_bubble,
    output logic             squash,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] annul_cnt,
    output logic             fsm_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0] op;
    logic [4:0] rd, rs1, rs2;
    logic [3:0] cond;
    logic       annul_bit, imm_sel;
    logic       is_bicc, is_call, is_jmpl, is_store, reads_regs;
    logic       cond_true, xfer_taken;
    logic       load_use, cc_hazard, hazard;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] annul_cnt_q, annul_cnt_d;
    logic             stall_inc, taken_inc, annul_inc;

    assign op        = instruction_in[31:30];
    assign annul_bit = instruction_in[29];
    assign rd        = instruction_in[29:25];
    assign cond      = instruction_in[28:25];
    assign rs1       = instruction_in[18:14];
    assign imm_sel   = instruction_in[13];
    assign rs2       = instruction_in[4:0];

    assign is_bicc    = (op == OP_FMT2) && (instruction_in[24:22] == OP2_BICC);
    assign is_call    = (op == OP_CALL);
    assign is_jmpl    = (op == OP_ARITH) && (instruction_in[24:19] == OP3_JMPL);
    assign is_store   = (op == OP_MEM) && (instruction_in[24:21] == OP3_STORE_HI);
    assign reads_regs = (op == OP_ARITH) || (op == OP_MEM);

    always_comb begin
        ta = pc_in + 32'd4;
        if (is_bicc) ta = pc_in + {{8{instruction_in[21]}}, instruction_in[21:0], 2'b00};
        else if (is_call) ta = pc_in + {instruction_in[29:0], 2'b00};
    end

    id_cond_eval u_cond_eval (
        .cond  (cond),
        .icc   (icc),
        .taken (cond_true)
    );

    assign xfer_taken = (is_bicc && cond_true) || is_call || is_jmpl;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) && reads_regs &&
                      ((ex_rd == rs1) || (!imm_sel && (ex_rd == rs2)) ||
                       (is_store && (ex_rd == rd)));
    assign cc_hazard = is_bicc && (cond[2:0] != 3'b000) && ex_sets_cc;
    assign hazard    = load_use || cc_hazard;

    // Reset forces a bubble with free-running enables; SQUASH ignores the ID word.
    always_comb begin
        pc_sel      = SEL_NPC;
        pc_le       = 1'b1;
        npc_le      = 1'b1;
        ifid_le     = 1'b1;
        idex_bubble = 1'b0;
        squash      = 1'b0;
        state_d     = ST_RUN;
        stall_inc   = 1'b0;
        taken_inc   = 1'b0;
        annul_inc   = 1'b0;
        if (!R_n) begin
            idex_bubble = 1'b1;
        end else if (state_q == ST_SQUASH) begin
            squash      = 1'b1;
            idex_bubble = 1'b1;
            annul_inc   = 1'b1;
        end else if (hazard) begin
            pc_le       = 1'b0;
            npc_le      = 1'b0;
            ifid_le     = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
        end else begin
            if (xfer_taken) begin
                pc_sel    = is_jmpl ? SEL_ALU : SEL_TA;
                taken_inc = 1'b1;
            end
            if (is_bicc && annul_bit && (!cond_true || cond == COND_BA))
                state_d = ST_SQUASH;
        end
    end

    assign ifid_clear = 1'b0;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        taken_cnt_d = taken_cnt_q;
        annul_cnt_d = annul_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            taken_cnt_d = '0;
            annul_cnt_d = '0;
        end else begin
            if (stall_inc && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
            if (taken_inc && taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + CNT_ONE;
            if (annul_inc && annul_cnt_q != '1) annul_cnt_d = annul_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge R_n) begin
        if (!R_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            taken_cnt_q <= '0;
            annul_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            taken_cnt_q <= taken_cnt_d;
            annul_cnt_q <= annul_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign taken_cnt = taken_cnt_q;
    assign annul_cnt = annul_cnt_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_id_branch_hazard_ctrl.sv
// Randomized and directed bench for id_branch_hazard_ctrl with a queue-based
// scoreboard fed by a behavioural model of the decode-stage rules.
module tb_id_branch_hazard_ctrl;

    localparam int CNT_W = 2;
    localparam int W = 41 + 3 * CNT_W;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             R_n;
    logic [31:0]      instruction_in;
    logic [31:0]      pc_in;
    logic [3:0]       icc;
    logic             ex_sets_cc;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             cnt_clr;
    logic [1:0]       pc_sel;
    logic [31:0]      ta;
    logic             pc_le, npc_le, ifid_le, ifid_clear, idex_bubble, squash;
    logic [CNT_W-1:0] stall_cnt, taken_cnt, annul_cnt;
    logic             fsm_state;

    id_branch_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .R_n            (R_n),
        .instruction_in (instruction_in),
        .pc_in          (pc_in),
        .icc            (icc),
        .ex_sets_cc     (ex_sets_cc),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .cnt_clr        (cnt_clr),
        .pc_sel         (pc_sel),
        .ta             (ta),
        .pc_le          (pc_le),
        .npc_le         (npc_le),
        .ifid_le        (ifid_le),
        .ifid_clear     (ifid_clear),
        .idex_bubble    (idex_bubble),
        .squash         (squash),
        .stall_cnt      (stall_cnt),
        .taken_cnt      (taken_cnt),
        .annul_cnt      (annul_cnt),
        .fsm_state      (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    bit             m_in_slot;
    int             m_stall, m_taken, m_annul;
    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    logic [W-1:0]   exp_q[$];

    function automatic bit cond_holds(input logic [3:0] cond, input logic [3:0] cc);
        bit n, z, v, c, r;
        n = cc[3]; z = cc[2]; v = cc[1]; c = cc[0];
        case (int'(cond[2:0]))
            0: r = 0;
            1: r = z;
            2: r = z | (n ^ v);
            3: r = n ^ v;
            4: r = c | z;
            5: r = c;
            6: r = n;
            default: r = v;
        endcase
        return cond[3] ? !r : r;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic rn, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [3:0] cc, input logic sets, input logic mr,
                         input logic [4:0] erd, input logic clr);
        int          op;
        bit          bicc, call, jmpl, reads, load_use, cc_haz, stall, ctrue, tk;
        logic [31:0] exp_ta;
        logic signed [31:0] disp;
        logic [1:0]  e_sel;
        logic        e_le, e_bub, e_sq, e_st;
        @(negedge clk);
        cyc++;
        R_n = rn; instruction_in = inst; pc_in = pc; icc = cc;
        ex_sets_cc = sets; ex_mem_read = mr; ex_rd = erd; cnt_clr = clr;

        op   = int'(inst[31:30]);
        bicc = (op == 0) && (inst[24:22] == 3'b010);
        call = (op == 1);
        jmpl = (op == 2) && (inst[24:19] == 6'b111000);
        disp = $signed({{10{inst[21]}}, inst[21:0]});
        if (bicc) exp_ta = pc + 32'(disp * 4);
        else if (call) exp_ta = pc + {inst[29:0], 2'b00};
        else exp_ta = pc + 32'd4;

        reads    = (op == 2) || (op == 3);
        load_use = mr && (erd != 0) && reads &&
                   (erd == inst[18:14] || (!inst[13] && erd == inst[4:0]) ||
                    (op == 3 && inst[24:21] == 4'b0001 && erd == inst[29:25]));
        cc_haz   = bicc && (inst[27:25] != 0) && sets;
        ctrue    = cond_holds(inst[28:25], cc);
        tk       = (bicc && ctrue) || call || jmpl;

        if (!rn) begin
            m_in_slot = 0; m_stall = 0; m_taken = 0; m_annul = 0;
        end
        e_sel = 2'b00; e_le = 1; e_bub = 1; e_sq = 0; e_st = m_in_slot;
        stall = 0;
        if (rn && !m_in_slot) begin
            stall = load_use || cc_haz;
            if (stall) e_le = 0;
            else begin
                e_bub = 0;
                if (tk) e_sel = jmpl ? 2'b10 : 2'b01;
            end
        end else if (rn) begin
            e_sq = 1;
        end
        exp_q.push_back({e_sel, exp_ta, e_le, e_le, e_le, 1'b0, e_bub, e_sq, e_st,
                         CNT_W'(m_stall), CNT_W'(m_taken), CNT_W'(m_annul)});

        // state after the coming rising edge
        if (rn) begin
            if (m_in_slot) begin
                m_in_slot = 0;
                m_annul = sat_inc(m_annul);
            end else if (stall) begin
                m_stall = sat_inc(m_stall);
            end else begin
                if (tk) m_taken = sat_inc(m_taken);
                m_in_slot = bicc && inst[29] && (!ctrue || inst[28:25] == 4'b1000);
            end
            if (clr) begin
                m_stall = 0; m_taken = 0; m_annul = 0;
            end
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] x;
        x = $urandom();
        case ($urandom_range(0, 7))
            0, 1: begin x[31:30] = 2'b00; x[24:22] = 3'b010; end
            2: x[31:30] = 2'b01;
            3: begin
                x[31:30] = 2'b10; x[24:19] = 6'b111000; x[18:14] = 5'($urandom_range(0, 7));
            end
            4: begin
                x[31:30] = 2'b10; x[18:14] = 5'($urandom_range(0, 7));
                x[4:0] = 5'($urandom_range(0, 7));
            end
            5: begin
                x[31:30] = 2'b11; x[29:25] = 5'($urandom_range(0, 7));
                x[24:19] = ($urandom_range(0, 1) == 1) ? 6'b000100 : 6'b000000;
                x[18:14] = 5'($urandom_range(0, 7)); x[4:0] = 5'($urandom_range(0, 7));
            end
            6: x = 32'd0;
            default: begin x[31:30] = 2'b00; x[24:22] = 3'b100; end
        endcase
        return x;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] exp_v, got_v;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                got_v = {pc_sel, ta, pc_le, npc_le, ifid_le, ifid_clear, idex_bubble,
                         squash, fsm_state, stall_cnt, taken_cnt, annul_cnt};
                checks++;
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got sel/ta/le3/clr/bub/sq/st/cnt=%h, expected %h",
                             cyc, got_v, exp_v);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [31:0] NOP      = 32'd0;
    localparam logic [31:0] BE       = {2'b00, 1'b0, 4'b0001, 3'b010, 22'd3};
    localparam logic [31:0] BNE_A    = {2'b00, 1'b1, 4'b1001, 3'b010, 22'd8};
    localparam logic [31:0] BA_A     = {2'b00, 1'b1, 4'b1000, 3'b010, 22'h3FFFFF};
    localparam logic [31:0] ADD_R5   = {2'b10, 5'd1, 6'd0, 5'd5, 1'b0, 8'd0, 5'd2};
    localparam logic [31:0] ADD_IMM5 = {2'b10, 5'd1, 6'd0, 5'd1, 1'b1, 13'd5};
    localparam logic [31:0] BG       = {2'b00, 1'b0, 4'b1010, 3'b010, 22'd16};
    localparam logic [31:0] JMPL     = {2'b10, 5'd15, 6'b111000, 5'd1, 1'b1, 13'd8};
    localparam logic [31:0] DSLOT    = {2'b10, 5'd3, 6'd0, 5'd4, 1'b1, 13'd1};

    initial begin
        R_n = 1'b0; instruction_in = '0; pc_in = '0; icc = '0;
        ex_sets_cc = 0; ex_mem_read = 0; ex_rd = '0; cnt_clr = 0;
        m_in_slot = 0; m_stall = 0; m_taken = 0; m_annul = 0;

        drive(0, BE, 32'h40, 4'b0100, 0, 0, 5'd0, 0);
        drive(0, rand_inst(), 32'h44, 4'h0, 1, 1, 5'd3, 0);
        drive(1, BE, 32'h40, 4'b0100, 0, 0, 5'd0, 0);
        drive(1, DSLOT, 32'h44, 4'b0100, 0, 0, 5'd0, 0);
        drive(1, BNE_A, 32'h50, 4'b0100, 0, 0, 5'd0, 0);
        drive(1, DSLOT, 32'h54, 4'b0100, 0, 0, 5'd0, 0);
        drive(1, BA_A, 32'h100, 4'h0, 0, 0, 5'd0, 0);
        drive(1, DSLOT, 32'h104, 4'h0, 0, 0, 5'd0, 0);
        drive(1, ADD_R5, 32'h200, 4'h0, 0, 1, 5'd5, 0);
        drive(1, ADD_R5, 32'h200, 4'h0, 0, 0, 5'd3, 0);
        drive(1, ADD_IMM5, 32'h204, 4'h0, 0, 1, 5'd5, 0);
        drive(1, BG, 32'h300, 4'b0100, 1, 0, 5'd0, 0);
        drive(1, BG, 32'h300, 4'b0100, 1, 0, 5'd0, 0);
        drive(1, BG, 32'h300, 4'b0000, 0, 0, 5'd0, 0);
        drive(1, JMPL, 32'h400, 4'h0, 0, 0, 5'd0, 0);
        drive(1, BA_A, 32'h500, 4'h0, 0, 0, 5'd0, 0);
        drive(0, DSLOT, 32'h504, 4'h0, 0, 0, 5'd0, 0);
        drive(1, NOP, 32'h504, 4'h0, 0, 0, 5'd0, 1);
        for (int i = 0; i < 5; i++) drive(1, ADD_R5, 32'h600, 4'h0, 0, 1, 5'd5, 0);
        drive(1, NOP, 32'h604, 4'h0, 0, 0, 5'd0, 0);

        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 60) != 0), rand_inst(), $urandom(),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 15) == 0));
        end

        @(negedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
